// File: rtl/uio_arb_pkg.sv
// Shared types and constants for the uio pad-bus arbiter.
package uio_arb_pkg;

    localparam int unsigned BUS_W = 8;

    localparam logic [BUS_W-1:0] OE_DRIVE   = 8'hFF;
    localparam logic [BUS_W-1:0] OE_RELEASE = 8'h00;

    localparam logic DIR_RD = 1'b0;
    localparam logic DIR_WR = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        TURN,
        XFER
    } arb_state_t;

    function automatic logic [BUS_W-1:0] oe_for_dir(input logic dir);
        return (dir == DIR_WR) ? OE_DRIVE : OE_RELEASE;
    endfunction

endpackage

// File: rtl/uio_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after rr_ptr, cyclic.
module rr_pick #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic               any_valid
);

    logic        found;
    logic [31:0] ptr_ext;

    assign ptr_ext   = 32'(rr_ptr);
    assign any_valid = |req;

    // Two passes: upper segment [ptr..N-1] first, then wrap to [0..ptr-1].
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found && (i >= ptr_ext) && req[i]) begin
                winner[i] = 1'b1;
                found     = 1'b1;
            end
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found && (i < ptr_ext) && req[i]) begin
                winner[i] = 1'b1;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uio_bus_arbiter.sv
// Round-robin arbiter sharing the bidirectional uio pad bus between NUM_REQ
// engines, with bounded hold per grant and bus turnaround on direction change.
module uio_bus_arbiter
    import uio_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 3,
    parameter int unsigned MAX_HOLD   = 4,
    parameter int unsigned TURNAROUND = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ena,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ-1:0]       req_wr,
    input  logic [BUS_W*NUM_REQ-1:0] req_wdata,
    input  logic [NUM_REQ-1:0]       req_last,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       beat,
    output logic [BUS_W-1:0]         rdata,
    output logic                     rvalid,
    output logic                     busy,
    input  logic [BUS_W-1:0]         uio_in,
    output logic [BUS_W-1:0]         uio_out,
    output logic [BUS_W-1:0]         uio_oe
);

    localparam int unsigned PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned TURN_W = 2;

    arb_state_t          state;
    logic [PTR_W-1:0]    rr_ptr;
    logic                bus_dir;
    logic                grant_dir;
    logic [CNT_W-1:0]    beat_cnt;
    logic [TURN_W-1:0]   turn_cnt;
    logic [BUS_W-1:0]    wdata_q;

    logic [NUM_REQ-1:0]  win_oh;
    logic                win_any;
    logic [PTR_W-1:0]    win_idx;
    logic [PTR_W-1:0]    next_ptr;
    logic                win_wr;
    logic                g_req;
    logic                g_last;
    logic [BUS_W-1:0]    g_wdata;
    logic                xfer_beat;
    logic                hold_done;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req       (req),
        .rr_ptr    (rr_ptr),
        .winner    (win_oh),
        .any_valid (win_any)
    );

    always_comb begin
        win_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (win_oh[i]) win_idx = PTR_W'(i);
        end
    end

    assign next_ptr = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
    assign win_wr   = |(win_oh & req_wr);
    assign g_req    = |(gnt & req);
    assign g_last   = |(gnt & req_last);

    always_comb begin
        g_wdata = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) g_wdata = req_wdata[BUS_W*i +: BUS_W];
        end
    end

    assign xfer_beat = (state == XFER) && g_req;
    assign hold_done = (beat_cnt == CNT_W'(MAX_HOLD - 1));
    assign beat      = xfer_beat ? gnt : '0;
    assign busy      = (state != IDLE);

    // Idle bus stays parked in the last direction unless the design is disabled.
    always_comb begin
        uio_oe = OE_RELEASE;
        unique case (state)
            IDLE:    uio_oe = ena ? oe_for_dir(bus_dir) : OE_RELEASE;
            TURN:    uio_oe = OE_RELEASE;
            XFER:    uio_oe = oe_for_dir(bus_dir);
            default: uio_oe = OE_RELEASE;
        endcase
    end

    assign uio_out = (xfer_beat && (bus_dir == DIR_WR)) ? g_wdata : wdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= '0;
            rr_ptr    <= '0;
            bus_dir   <= DIR_RD;
            grant_dir <= DIR_RD;
            beat_cnt  <= '0;
            turn_cnt  <= '0;
            wdata_q   <= '0;
            rdata     <= '0;
            rvalid    <= 1'b0;
        end else begin
            rvalid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!ena) begin
                        bus_dir <= DIR_RD;
                    end else if (win_any) begin
                        gnt       <= win_oh;
                        rr_ptr    <= next_ptr;
                        grant_dir <= win_wr;
                        beat_cnt  <= '0;
                        turn_cnt  <= '0;
                        state     <= (win_wr != bus_dir) ? TURN : XFER;
                    end
                end
                TURN: begin
                    if (turn_cnt == TURN_W'(TURNAROUND - 1)) begin
                        bus_dir <= grant_dir;
                        state   <= XFER;
                    end else begin
                        turn_cnt <= turn_cnt + TURN_W'(1);
                    end
                end
                XFER: begin
                    if (!g_req) begin
                        state    <= IDLE;
                        gnt      <= '0;
                        beat_cnt <= '0;
                    end else begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                        if (bus_dir == DIR_WR) begin
                            wdata_q <= g_wdata;
                        end else begin
                            rdata  <= uio_in;
                            rvalid <= 1'b1;
                        end
                        if (g_last || hold_done || !ena) begin
                            state    <= IDLE;
                            gnt      <= '0;
                            beat_cnt <= '0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Scoreboard bench for uio_bus_arbiter (NUM_REQ=3, MAX_HOLD=4, TURNAROUND=1).
module tb_uio_bus_arbiter;

    typedef struct packed {
        logic [2:0] b;
        logic [7:0] oe;
        logic [7:0] dout;
    } beat_exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic [2:0]  req;
    logic [2:0]  req_wr;
    logic [23:0] req_wdata;
    logic [2:0]  req_last;
    logic [2:0]  gnt;
    logic [2:0]  beat;
    logic [7:0]  rdata;
    logic        rvalid;
    logic        busy;
    logic [7:0]  uio_in;
    logic [7:0]  uio_out;
    logic [7:0]  uio_oe;

    beat_exp_t   beat_q[$];
    logic [7:0]  rd_q[$];
    beat_exp_t   mon_e;
    logic [7:0]  mon_rd;
    logic        mon_en = 1'b0;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int          eg, eo, k;

    always #5 clk = ~clk;

    uio_bus_arbiter #(
        .NUM_REQ    (3),
        .MAX_HOLD   (4),
        .TURNAROUND (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .req       (req),
        .req_wr    (req_wr),
        .req_wdata (req_wdata),
        .req_last  (req_last),
        .gnt       (gnt),
        .beat      (beat),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .busy      (busy),
        .uio_in    (uio_in),
        .uio_out   (uio_out),
        .uio_oe    (uio_oe)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
        end
    endtask

    task automatic push_beat(input logic [2:0] b, input logic [7:0] oe, input logic [7:0] d);
        beat_q.push_back('{b: b, oe: oe, dout: d});
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic half();
        @(negedge clk);
    endtask

    // Monitor: pops an expectation whenever the DUT shows a beat or read data.
    always @(negedge clk) begin
        if (mon_en) begin
            if (beat != 3'b000) begin
                if (beat_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_beat: got beat=%b expected none", beat);
                end else begin
                    mon_e = beat_q.pop_front();
                    chk("beat", 32'(beat), 32'(mon_e.b));
                    chk("beat_gnt", 32'(gnt), 32'(mon_e.b));
                    chk("beat_oe", 32'(uio_oe), 32'(mon_e.oe));
                    if (mon_e.oe == 8'hFF) chk("beat_out", 32'(uio_out), 32'(mon_e.dout));
                end
            end
            if (rvalid) begin
                if (rd_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_rvalid: got rdata=0x%0h expected none", rdata);
                end else begin
                    mon_rd = rd_q.pop_front();
                    chk("rdata", 32'(rdata), 32'(mon_rd));
                end
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with all requests asserted
        rst = 1'b1; ena = 1'b1; req = 3'b111; req_wr = 3'b111; req_last = 3'b000;
        req_wdata = 24'h332211; uio_in = 8'h00;
        next();
        mon_en = 1'b1;
        half();
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_beat", 32'(beat), 0);
        chk("rst_oe", 32'(uio_oe), 0);
        chk("rst_out", 32'(uio_out), 0);
        chk("rst_rvalid", 32'(rvalid), 0);
        chk("rst_busy", 32'(busy), 0);
        next();

        // Single write burst from requester 0
        rst = 1'b0; req = 3'b001; req_wr = 3'b001; req_wdata = 24'h0000A5;
        push_beat(3'b001, 8'hFF, 8'hA5);
        push_beat(3'b001, 8'hFF, 8'hA5);
        half(); chk("w_c0_gnt", 32'(gnt), 0); chk("w_c0_busy", 32'(busy), 0); next();
        half(); chk("w_c1_gnt", 32'(gnt), 3'b001); chk("w_c1_oe", 32'(uio_oe), 8'h00);
                chk("w_c1_beat", 32'(beat), 0); chk("w_c1_busy", 32'(busy), 1); next();
        half(); chk("w_c2_oe", 32'(uio_oe), 8'hFF); next();
        req_last = 3'b001;
        half(); next();
        req = 3'b000; req_last = 3'b000;
        half(); chk("w_c4_gnt", 32'(gnt), 0); chk("w_c4_oe", 32'(uio_oe), 8'hFF);
                chk("w_c4_out", 32'(uio_out), 8'hA5); chk("w_c4_busy", 32'(busy), 0); next();

        // Read after write from requester 1
        req = 3'b010; req_wr = 3'b000; uio_in = 8'h3C;
        push_beat(3'b010, 8'h00, 8'h00);
        rd_q.push_back(8'h3C);
        half(); chk("r_c0_oe", 32'(uio_oe), 8'hFF); chk("r_c0_gnt", 32'(gnt), 0); next();
        half(); chk("r_c1_gnt", 32'(gnt), 3'b010); chk("r_c1_oe", 32'(uio_oe), 8'h00); next();
        req_last = 3'b010;
        half(); chk("r_c2_oe", 32'(uio_oe), 8'h00); next();
        req = 3'b000; req_last = 3'b000; uio_in = 8'h00;
        half(); chk("r_c3_gnt", 32'(gnt), 0); next();
        half(); chk("r_c4_rvalid", 32'(rvalid), 0); next();

        // Requester 2 drops mid-burst; requester 0 (read) wins next
        req = 3'b101; req_wr = 3'b100; req_wdata = 24'h5A0000;
        push_beat(3'b100, 8'hFF, 8'h5A);
        push_beat(3'b100, 8'hFF, 8'h5A);
        push_beat(3'b001, 8'h00, 8'h00);
        rd_q.push_back(8'h96);
        half(); chk("d_c0_gnt", 32'(gnt), 0); next();
        half(); chk("d_c1_gnt", 32'(gnt), 3'b100); chk("d_c1_oe", 32'(uio_oe), 8'h00); next();
        half(); next();
        half(); next();
        req = 3'b001;
        half(); chk("d_c4_gnt", 32'(gnt), 3'b100); chk("d_c4_beat", 32'(beat), 0);
                chk("d_c4_busy", 32'(busy), 1); next();
        half(); chk("d_c5_gnt", 32'(gnt), 0); chk("d_c5_busy", 32'(busy), 0);
                chk("d_c5_oe", 32'(uio_oe), 8'hFF); next();
        half(); chk("d_c6_gnt", 32'(gnt), 3'b001); chk("d_c6_oe", 32'(uio_oe), 8'h00); next();
        req_last = 3'b001; uio_in = 8'h96;
        half(); next();
        req = 3'b000; req_last = 3'b000;
        half(); chk("d_c8_gnt", 32'(gnt), 0); next();

        // Round robin after a fresh reset: all write, no req_last
        rst = 1'b1; req = 3'b000;
        next();
        rst = 1'b0; req = 3'b111; req_wr = 3'b111; req_wdata = 24'h332211;
        for (int n = 0; n < 4; n++) begin
            for (int b = 0; b < 4; b++) begin
                push_beat(3'(1 << (n % 3)), 8'hFF, 8'(8'h11 * ((n % 3) + 1)));
            end
        end
        for (int c = 0; c < 22; c++) begin
            if (c == 21) req = 3'b000;
            if (c == 0) eg = 0;
            else if (c <= 5) eg = 1;
            else begin
                k = c - 6;
                eg = ((k % 5) == 0) ? 0 : (1 << (((k / 5) + 1) % 3));
            end
            eo = (c <= 1) ? 8'h00 : 8'hFF;
            half();
            chk($sformatf("rr_c%0d_gnt", c), 32'(gnt), 32'(eg));
            chk($sformatf("rr_c%0d_oe", c), 32'(uio_oe), 32'(eo));
            next();
        end

        // ena drops during a write burst from requester 1
        req = 3'b010; req_wr = 3'b010; req_wdata = 24'h007700; ena = 1'b1;
        push_beat(3'b010, 8'hFF, 8'h77);
        push_beat(3'b010, 8'hFF, 8'h77);
        half(); chk("e_c0_gnt", 32'(gnt), 0); next();
        half(); chk("e_c1_gnt", 32'(gnt), 3'b010); chk("e_c1_oe", 32'(uio_oe), 8'hFF); next();
        ena = 1'b0;
        half(); chk("e_c2_beat", 32'(beat), 3'b010); next();
        half(); chk("e_c3_gnt", 32'(gnt), 0); chk("e_c3_oe", 32'(uio_oe), 8'h00);
                chk("e_c3_busy", 32'(busy), 0); next();
        half(); chk("e_c4_gnt", 32'(gnt), 0); chk("e_c4_busy", 32'(busy), 0); next();
        half(); chk("e_c5_gnt", 32'(gnt), 0); chk("e_c5_oe", 32'(uio_oe), 8'h00); next();
        req = 3'b000; ena = 1'b1;
        half(); chk("e_c6_oe", 32'(uio_oe), 8'h00); next();

        // Reset during a read burst from requester 2
        req = 3'b100; req_wr = 3'b000; uio_in = 8'hE7;
        push_beat(3'b100, 8'h00, 8'h00);
        half(); next();
        rst = 1'b1;
        half(); chk("x_c1_gnt", 32'(gnt), 3'b100); next();
        rst = 1'b0; req = 3'b000;
        half(); chk("x_gnt", 32'(gnt), 0); chk("x_beat", 32'(beat), 0);
                chk("x_oe", 32'(uio_oe), 8'h00); chk("x_out", 32'(uio_out), 8'h00);
                chk("x_rvalid", 32'(rvalid), 0); chk("x_rdata", 32'(rdata), 8'h00);
                chk("x_busy", 32'(busy), 0); next();
        next();
        next();

        chk("beat_q_empty", 32'(beat_q.size()), 0);
        chk("rd_q_empty", 32'(rd_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
